diff_stage: RTL
===============

DIFF_STAGE -- requirements
Module: diff_stage

Interface
REQ-001 Parameter DW, default 32: sample width, signed two's complement, Q(DW-16).15 fixed point.
REQ-002 Parameter MAXD, default 2: maximum differencing order supported.
REQ-003 clk  in  1  rising-edge clock, single clock domain.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low; release synchronous to clk.
REQ-005 control  in  2  mode: 00 run, 01 stall, 10 load config, 11 clear.
REQ-006 d_order_in  in  32  differencing order; sampled only in load config.
REQ-007 in_data  in  DW  raw series sample x(t).
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_ready  out  1  block accepts in_data this cycle.
REQ-010 out_data  out  DW  differenced sample y(t), fed to the AR/MA stages.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_ready  in  1  downstream accepts out_data.
REQ-013 sat  out  1  sticky: at least one output saturated since last config/clear.
REQ-014 cfg_err  out  1  sticky: last loaded d_order_in exceeded MAXD.

Function
REQ-015 Input transfer occurs when in_valid and in_ready are both 1 on a rising clk edge; output transfer likewise when out_valid and out_ready are both 1.
REQ-016 in_ready = (control==00) and (output register empty, or out_ready==1); combinational, no dependence on in_valid.
REQ-017 Port out_valid = internal valid register AND (control!=01); internal register and out_data hold unchanged during stall.
REQ-018 History: registers h1=x(t-1), h2=x(t-2); on each input transfer h2<=h1, h1<=in_data.
REQ-019 Warm-up counter w counts accepted samples, saturating at d; a transfer with w<d increments w and produces no output.
REQ-020 A transfer with w==d loads the output register next edge: latency exactly 1 cycle from input transfer to out_valid.
REQ-021 d=0: y=x; d=1: y=x-h1; d=2: y=x-2*h1+h2.
REQ-022 Arithmetic at DW+2 bits signed, then saturated to DW bits: >2^(DW-1)-1 -> 0x7FFFFFFF, <-2^(DW-1) -> 0x80000000; saturation sets sat.
REQ-023 Internal valid clears on output transfer without a simultaneous input transfer that produces output; simultaneous out and in transfers sustain one sample per cycle with no bubble.
REQ-024 Load config (10), while held: latch d=min(d_order_in, MAXD); cfg_err=(d_order_in>MAXD); clear h1, h2, w, internal valid, sat; in_ready=0.
REQ-025 Clear (11): all registers incl. d and cfg_err to 0; in_ready=0.
REQ-026 Any pending output is discarded by load config or clear; no partial transfer is produced.
REQ-027 out_data is driven from a register only; no combinational path from in_data to out_data.

Reset
REQ-028 rst_n low asynchronously forces d=0, h1=h2=0, w=0, out_data=0, out_valid=0, sat=0, cfg_err=0; in_ready=0 while rst_n is low.
REQ-029 Reset asserted mid-stream drops any in-flight sample; first post-reset sample is treated as warm-up per the current d (=0).

Verification
REQ-030 Load d=1; feed 32768, 98304, 65536 with out_ready=1 -> no output for the first sample, then 65536, -32768, each one cycle after acceptance.
REQ-031 Load d=2; feed 0, 32768, 98304, 196608 -> outputs 32768, 32768 only; sat=0.
REQ-032 Load d=1; feed 0x80000000 then 0x7FFFFFFF -> out_data=0x7FFFFFFF and sat=1 until next load.
REQ-033 d=0, out_ready=0 with continuous in_valid -> one sample accepted, in_ready drops, out_data held stable; raising out_ready gives one sample per cycle with no loss or duplication.
REQ-034 Control=01 for 3 cycles with data pending -> out_valid=0 and in_ready=0; returning to 00 restores the same out_data; d_order_in=5 on load -> d=2 and cfg_err=1.
REQ-035 rst_n pulsed low mid-stream with out_valid=1 -> out_valid=0 immediately (asynchronous); after release, d=0 passthrough with 1-cycle latency.

Source files
------------

// File: rtl/diff_stage_if.sv
// Sample stream into and differenced stream out of diff_stage.
// A beat transfers on a rising clk edge where valid and ready are both 1; a source holds data stable while valid waits for ready.
interface diff_stage_if #(
    parameter int DW = 32
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/diff_stage.sv
// Streaming d-th order differencer (d = 0, 1, 2) with saturation, stall, config load and clear modes.
// Supported differencing orders are 0, 1 and 2, so MAXD takes one of those values.
module diff_stage #(
    parameter int DW   = 32,
    parameter int MAXD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  control,
    input  logic [31:0] d_order_in,
    diff_stage_if.slave bus,
    output logic        sat,
    output logic        cfg_err
);
    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_STALL = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    localparam int EW = DW + 2;
    localparam logic [1:0] MAXD_C = 2'(MAXD);
    localparam logic signed [EW-1:0] POS_LIM = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] NEG_LIM = {3'b111, {(DW-1){1'b0}}};

    logic [1:0]    d_q, d_d;
    logic [1:0]    w_q, w_d;
    logic [DW-1:0] h1_q, h1_d;
    logic [DW-1:0] h2_q, h2_d;
    logic [DW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          sat_q, sat_d;
    logic          cfg_err_q, cfg_err_d;

    logic                 in_fire, out_fire, produce;
    logic signed [EW-1:0] x_e, h1_e, h2_e, y_e;
    logic [DW-1:0]        y_sat;
    logic                 ovf;

    // ---------------- output process ----------------
    always_comb begin
        bus.in_ready  = rst_n && (control == MODE_RUN) && (!valid_q || bus.out_ready);
        bus.out_valid = valid_q && (control != MODE_STALL);
        bus.out_data  = out_q;
        sat           = sat_q;
        cfg_err       = cfg_err_q;
    end

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign produce  = in_fire && (w_q == d_q);

    // Widened by two bits so x - 2*h1 + h2 cannot wrap before saturation.
    assign x_e  = {{2{bus.in_data[DW-1]}}, bus.in_data};
    assign h1_e = {{2{h1_q[DW-1]}}, h1_q};
    assign h2_e = {{2{h2_q[DW-1]}}, h2_q};

    always_comb begin
        y_e = x_e;
        case (d_q)
            2'd0:    y_e = x_e;
            2'd1:    y_e = x_e - h1_e;
            default: y_e = x_e - (h1_e <<< 1) + h2_e;
        endcase
        ovf   = 1'b0;
        y_sat = y_e[DW-1:0];
        if (y_e > POS_LIM) begin
            ovf   = 1'b1;
            y_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (y_e < NEG_LIM) begin
            ovf   = 1'b1;
            y_sat = {1'b1, {(DW-1){1'b0}}};
        end
    end

    // ---------------- next-state process ----------------
    always_comb begin
        d_d       = d_q;
        w_d       = w_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
        out_d     = out_q;
        valid_d   = valid_q;
        sat_d     = sat_q;
        cfg_err_d = cfg_err_q;
        case (control)
            MODE_RUN: begin
                if (in_fire) begin
                    h2_d = h1_q;
                    h1_d = bus.in_data;
                    if (w_q < d_q) w_d = w_q + 2'd1;
                end
                if (produce) begin
                    out_d   = y_sat;
                    valid_d = 1'b1;
                    if (ovf) sat_d = 1'b1;
                end else if (out_fire) begin
                    valid_d = 1'b0;
                end
            end
            MODE_STALL: begin
            end
            MODE_LOAD: begin
                d_d       = (d_order_in > 32'(MAXD)) ? MAXD_C : d_order_in[1:0];
                cfg_err_d = (d_order_in > 32'(MAXD));
                h1_d      = '0;
                h2_d      = '0;
                w_d       = '0;
                valid_d   = 1'b0;
                sat_d     = 1'b0;
            end
            default: begin
                d_d       = '0;
                w_d       = '0;
                h1_d      = '0;
                h2_d      = '0;
                out_d     = '0;
                valid_d   = 1'b0;
                sat_d     = 1'b0;
                cfg_err_d = 1'b0;
            end
        endcase
    end

    // ---------------- state register process ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q       <= '0;
            w_q       <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            d_q       <= d_d;
            w_q       <= w_d;
            h1_q      <= h1_d;
            h2_q      <= h2_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
            cfg_err_q <= cfg_err_d;
        end
    end
endmodule
